// File: rtl/bnn_controller.sv
// Sequencer for a three-layer binarised network: LOAD, L1, L2, L3, DONE.
// Ports:
//   clk, reset_n                    clock and async active-low reset
//   start, abort                    run request and forced return to IDLE
//   load_done, l1_done..l3_done     completion levels from loader and layers
//   class_in[3:0]                   class index from layer 3, valid with l3_done
//   state[2:0]                      sequencing state bus to loader and layers
//   clr                             pulse in the first LOAD cycle
//   layer_start                     pulse in the first cycle of L1, L2 and L3
//   result[3:0], result_valid       latched class index and DONE flag
//   err, err_code[2:0]              ERR flag and the state that timed out
module bnn_controller #(
    parameter int unsigned LOAD_TIMEOUT  = 4096,
    parameter int unsigned LAYER_TIMEOUT = 1024
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       start,
    input  logic       abort,
    input  logic       load_done,
    input  logic       l1_done,
    input  logic       l2_done,
    input  logic       l3_done,
    input  logic [3:0] class_in,
    output logic [2:0] state,
    output logic       clr,
    output logic       layer_start,
    output logic [3:0] result,
    output logic       result_valid,
    output logic       err,
    output logic [2:0] err_code
);

    typedef enum logic [2:0] {
        S_IDLE = 3'b000,
        S_LOAD = 3'b001,
        S_L1   = 3'b010,
        S_L2   = 3'b011,
        S_L3   = 3'b100,
        S_DONE = 3'b101,
        S_ERR  = 3'b110
    } state_t;

    localparam logic [15:0] LOAD_LIM  = 16'(LOAD_TIMEOUT);
    localparam logic [15:0] LAYER_LIM = 16'(LAYER_TIMEOUT);

    state_t      cur;
    state_t      nxt;
    logic        entry;
    logic        to_err;
    logic        counting;
    logic [15:0] wd;

    assign counting = (cur == S_LOAD) || (cur == S_L1) ||
                      (cur == S_L2) || (cur == S_L3);

    always_comb begin
        nxt    = cur;
        to_err = 1'b0;
        case (cur)
            S_IDLE: if (start) nxt = S_LOAD;
            S_LOAD: begin
                // The loader is being cleared during the entry cycle, so a
                // stale load_done seen then belongs to the previous run.
                if (load_done && !entry) nxt = S_L1;
                else if (wd >= LOAD_LIM) to_err = 1'b1;
            end
            S_L1: begin
                if (l1_done) nxt = S_L2;
                else if (wd >= LAYER_LIM) to_err = 1'b1;
            end
            S_L2: begin
                if (l2_done) nxt = S_L3;
                else if (wd >= LAYER_LIM) to_err = 1'b1;
            end
            S_L3: begin
                if (l3_done) nxt = S_DONE;
                else if (wd >= LAYER_LIM) to_err = 1'b1;
            end
            S_DONE: if (start) nxt = S_LOAD;
            S_ERR:  nxt = S_ERR;
            default: nxt = S_IDLE;
        endcase
        if (to_err) nxt = S_ERR;
        if (abort) begin
            nxt    = S_IDLE;
            to_err = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cur      <= S_IDLE;
            entry    <= 1'b0;
            wd       <= 16'd0;
            result   <= 4'd0;
            err_code <= 3'd0;
        end else begin
            cur   <= nxt;
            entry <= (nxt != cur);
            if (nxt != cur)
                wd <= 16'd0;
            else if (counting && wd != 16'hFFFF)
                wd <= wd + 16'd1;
            if (cur == S_L3 && nxt == S_DONE)
                result <= class_in;
            if (to_err)
                err_code <= cur;
        end
    end

    assign state        = cur;
    assign clr          = entry && (cur == S_LOAD);
    assign layer_start  = entry && ((cur == S_L1) || (cur == S_L2) ||
                                    (cur == S_L3));
    assign result_valid = (cur == S_DONE);
    assign err          = (cur == S_ERR);

endmodule
